seri_div: RTL and testbench

SERI_DIV -- requirements
Module: seri_div

---
 rtl/seri_div_if.sv | 33 +++
 rtl/seri_div.sv | 121 ++++++++++++
 tb/tb_seri_div.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seri_div_if.sv
// seri_div_if -- operand/result bundle for the serial divider.
//   div_a      dividend (DW_N bits, unsigned), driven by the requester
//   div_b      divisor (DW_D bits, unsigned), driven by the requester
//   en_div     start request, only looked at while the divider is idle
//   quotient   registered quotient (DW_N bits)
//   remainder  registered remainder (DW_D bits)
//   div_zero   registered flag: last operation had a zero divisor
//   op_done    one-cycle completion pulse
//   busy       high while an operation is in flight
// The master modport is the requester side; the slave modport is the divider.
interface seri_div_if #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
);
    logic [DW_N-1:0] div_a;
    logic [DW_D-1:0] div_b;
    logic            en_div;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
    logic            div_zero;
    logic            op_done;
    logic            busy;

    modport master (
        output div_a, div_b, en_div,
        input  quotient, remainder, div_zero, op_done, busy
    );

    modport slave (
        input  div_a, div_b, en_div,
        output quotient, remainder, div_zero, op_done, busy
    );
endinterface

// File: rtl/seri_div.sv
// seri_div -- unsigned restoring divider, one quotient bit per clock.
//   clk    rising-edge clock
//   rstn   asynchronous active-low reset
//   bus    seri_div_if.slave: div_a/div_b/en_div in,
//          quotient/remainder/div_zero/op_done/busy out
// A nonzero division takes DW_N+3 cycles from start edge to the next
// possible start edge; a zero divisor completes on the start edge itself.
module seri_div #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic       clk,
    input  logic       rstn,
    seri_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_PRO = 2'd1,
        FINAL   = 2'd2
    } state_t;

    localparam int            CW       = $clog2(DW_N + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DW_N);

    state_t          state;
    logic [DW_N-1:0] dvd;
    logic [DW_D-1:0] dsr;
    logic [DW_D-1:0] prem;
    logic [CW-1:0]   cnt;
    logic [DW_N-1:0] quotient_r;
    logic [DW_D-1:0] remainder_r;
    logic            div_zero_r;
    logic            op_done_r;

    logic [DW_D:0]   trial;
    logic [DW_D:0]   diff;
    logic            take;

    // One restoring step: bring down the next dividend bit next to the
    // partial remainder and see whether the divisor fits. The partial
    // remainder always stays below the divisor, so DW_D bits hold it.
    always_comb begin
        trial = {prem, dvd[DW_N-1]};
        diff  = trial - {1'b0, dsr};
        take  = (trial >= {1'b0, dsr});
    end

    // Control FSM and datapath. The dividend register doubles as the
    // quotient accumulator: it shifts left each step and the new quotient
    // bit enters at the LSB, so after DW_N steps it holds the quotient.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            dvd         <= '0;
            dsr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            op_done_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Operands are tracked every idle cycle so the values
                    // present on the start edge are the ones used.
                    dvd       <= bus.div_a;
                    dsr       <= bus.div_b;
                    prem      <= '0;
                    cnt       <= '0;
                    op_done_r <= 1'b0;
                    if (bus.en_div) begin
                        if (bus.div_b == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= '0;
                            div_zero_r  <= 1'b1;
                            op_done_r   <= 1'b1;
                            state       <= FINAL;
                        end else begin
                            state <= DIV_PRO;
                        end
                    end
                end
                DIV_PRO: begin
                    if (cnt == CNT_DONE) begin
                        quotient_r  <= dvd;
                        remainder_r <= prem;
                        div_zero_r  <= 1'b0;
                        op_done_r   <= 1'b1;
                        state       <= FINAL;
                    end else begin
                        dvd  <= {dvd[DW_N-2:0], take};
                        prem <= take ? diff[DW_D-1:0] : trial[DW_D-1:0];
                        cnt  <= cnt + 1'b1;
                    end
                end
                FINAL: begin
                    op_done_r <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    // Unused encoding: recover to idle with a clean datapath.
                    dvd       <= '0;
                    dsr       <= '0;
                    prem      <= '0;
                    cnt       <= '0;
                    op_done_r <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.op_done   = op_done_r;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_seri_div.sv
// tb_seri_div -- self-checking bench for seri_div.
// Expected results come from plain integer division (a / b, a % b) plus
// the zero-divisor convention; timing expectations come from the stated
// start-to-done latencies. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_seri_div;

    localparam int DW_N = 16;
    localparam int DW_D = 8;
    localparam int LAT_NZ = DW_N + 2;   // falling edges from start to op_done, nonzero divisor
    localparam int PERIOD = DW_N + 3;   // cycles per op with en_div held high

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    seri_div_if #(.DW_N(DW_N), .DW_D(DW_D)) bus ();

    seri_div #(.DW_N(DW_N), .DW_D(DW_D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_quotient"},  32'(bus.quotient),  32'h0);
        checkOutput({tag, "_remainder"}, 32'(bus.remainder), 32'h0);
        checkOutput({tag, "_div_zero"},  32'(bus.div_zero),  32'h0);
        checkOutput({tag, "_op_done"},   32'(bus.op_done),   32'h0);
        checkOutput({tag, "_busy"},      32'(bus.busy),      32'h0);
    endtask

    // One directed operation. inject_at > 0 pulses en_div with 50/5 at that
    // falling edge (must be ignored); reset_at > 0 asserts rstn there instead
    // of letting the operation finish.
    task automatic applyStimulus(input string tag, input logic [DW_N-1:0] a,
                                 input logic [DW_D-1:0] b,
                                 input int inject_at, input int reset_at);
        logic [DW_N-1:0] exp_q;
        logic [DW_D-1:0] exp_r;
        logic            exp_z;
        int              exp_lat;
        int              n;
        bit              seen;
        bit              was_reset;
        bit              stray_done;

        if (b == 0) begin
            exp_q   = '1;
            exp_r   = '0;
            exp_z   = 1'b1;
            exp_lat = 1;
        end else begin
            exp_q   = DW_N'(int'(a) / int'(b));
            exp_r   = DW_D'(int'(a) % int'(b));
            exp_z   = 1'b0;
            exp_lat = LAT_NZ;
        end

        @(negedge clk);
        bus.div_a  = a;
        bus.div_b  = b;
        bus.en_div = 1'b1;
        n          = 0;
        seen       = 1'b0;
        was_reset  = 1'b0;
        while (n < 60 && !seen && !was_reset) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.en_div = 1'b0;
                checkOutput({tag, "_busy_after_start"}, 32'(bus.busy), 32'h1);
            end
            if (inject_at > 0 && n == inject_at) begin
                bus.div_a  = 50;
                bus.div_b  = 5;
                bus.en_div = 1'b1;
            end
            if (inject_at > 0 && n == inject_at + 1)
                bus.en_div = 1'b0;
            if (reset_at > 0 && n == reset_at) begin
                rstn = 1'b0;
                #1;
                checkReset({tag, "_midop_reset"});
                stray_done = 1'b0;
                repeat (25) begin
                    @(negedge clk);
                    if (bus.op_done !== 1'b0) stray_done = 1'b1;
                end
                checkOutput({tag, "_no_done_in_reset"}, 32'(stray_done), 32'h0);
                rstn      = 1'b1;
                was_reset = 1'b1;
            end
            if (!was_reset) seen = bus.op_done;
        end

        if (!was_reset) begin
            checkOutput({tag, "_latency"},   32'(n),             32'(exp_lat));
            checkOutput({tag, "_quotient"},  32'(bus.quotient),  32'(exp_q));
            checkOutput({tag, "_remainder"}, 32'(bus.remainder), 32'(exp_r));
            checkOutput({tag, "_div_zero"},  32'(bus.div_zero),  32'(exp_z));
            @(negedge clk);
            checkOutput({tag, "_done_pulse_width"}, 32'(bus.op_done), 32'h0);
            checkOutput({tag, "_idle_after"},       32'(bus.busy),    32'h0);
            repeat (3) @(negedge clk);
            checkOutput({tag, "_quotient_held"}, 32'(bus.quotient), 32'(exp_q));
        end
    endtask

    // Linear directed sequence followed by a back-to-back random stream.
    initial begin
        logic [DW_N-1:0] ra;
        logic [DW_D-1:0] rb;
        int              n;

        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        bus.div_a   = '0;
        bus.div_b   = '0;
        bus.en_div  = 1'b0;

        repeat (3) @(negedge clk);
        checkReset("power_on_reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus("1000_div_7",   16'd1000,  8'd7,    0, 0);
        applyStimulus("ffff_div_ff",  16'hFFFF,  8'hFF,   0, 0);
        applyStimulus("ffff_div_1",   16'hFFFF,  8'd1,    0, 0);
        applyStimulus("5_div_9",      16'd5,     8'd9,    0, 0);
        applyStimulus("1234_div_0",   16'h1234,  8'd0,    0, 0);
        applyStimulus("10_div_3",     16'd10,    8'd3,    0, 0);
        applyStimulus("ignore_start", 16'd1000,  8'd7,    5, 0);
        applyStimulus("reset_iter8",  16'd1000,  8'd7,    0, 9);
        applyStimulus("after_reset",  16'd10,    8'd3,    0, 0);

        // en_div held high: each completion must come exactly PERIOD cycles
        // after the previous one, and new operands are applied right after
        // op_done so they are the ones present on the next idle edge.
        @(negedge clk);
        ra         = 16'($urandom_range(0, 65535));
        rb         = 8'($urandom_range(1, 255));
        bus.div_a  = ra;
        bus.div_b  = rb;
        bus.en_div = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.op_done && n < 60);
            checkOutput("stream_spacing", 32'(n), (i == 0) ? 32'(LAT_NZ) : 32'(PERIOD));
            checkOutput("stream_quotient",  32'(bus.quotient),  32'(int'(ra) / int'(rb)));
            checkOutput("stream_remainder", 32'(bus.remainder), 32'(int'(ra) % int'(rb)));
            checkOutput("stream_identity",
                        32'(int'(bus.quotient) * int'(rb) + int'(bus.remainder)
                            + ((int'(bus.remainder) < int'(rb)) ? 0 : 32'h10000)),
                        32'(ra));
            ra        = 16'($urandom_range(0, 65535));
            rb        = 8'($urandom_range(1, 255));
            bus.div_a = ra;
            bus.div_b = rb;
            if (i == 999) bus.en_div = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkOutput("stream_stopped", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
